// File: rtl/shift_register_group_ctrl_if.sv
// shift_register_group_ctrl_if: valid/ready handshake bundle around the delay group
interface shift_register_group_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic out_last;
    modport master (output in_valid, out_ready, input in_ready, out_valid, out_last);
    modport slave (input in_valid, out_ready, output in_ready, out_valid, out_last);
endinterface

// File: rtl/shift_register_group_ctrl.sv
// shift_register_group_ctrl: valid/ready flow control, stall, flush and frame tracking for the 3-stage delay group
module shift_register_group_ctrl #(
    parameter int DEPTH     = 3,
    parameter int FRAME_LEN = 32,
    parameter int CNT_W     = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    shift_register_group_ctrl_if.slave hs,
    output logic                       sr_enable,
    output logic                       sr_clear,
    output logic                       frame_done,
    output logic [1:0]                 occupancy,
    output logic                       busy
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [CNT_W-1:0] in_idx_q, in_idx_d, out_idx_q, out_idx_d;
    logic             frame_done_q, frame_done_d;
    logic             adv, in_hs, out_hs;

    // group shifts whenever its output stage is empty or being consumed; outputs decode the valid shadow
    always_comb begin
        adv          = ~flush & reset & ~(v_q[DEPTH-1] & ~hs.out_ready);
        sr_enable    = adv;
        hs.in_ready  = adv;
        sr_clear     = flush | ~reset;
        hs.out_valid = v_q[DEPTH-1];
        hs.out_last  = v_q[DEPTH-1] & (out_idx_q == LAST_IDX);
        occupancy    = 2'(v_q[0]) + 2'(v_q[1]) + 2'(v_q[2]);
        busy         = |v_q;
        frame_done   = frame_done_q;
    end

    // next state: bubbles shift in lockstep with data, flush wins over any handshake
    always_comb begin
        in_hs        = hs.in_valid & adv;
        out_hs       = v_q[DEPTH-1] & hs.out_ready & ~flush;
        v_d          = flush ? '0 : adv ? {v_q[DEPTH-2:0], in_hs} : v_q;
        in_idx_d     = flush ? '0 : ~in_hs ? in_idx_q :
                       (in_idx_q == LAST_IDX) ? '0 : in_idx_q + CNT_W'(1);
        out_idx_d    = flush ? '0 : ~out_hs ? out_idx_q :
                       (out_idx_q == LAST_IDX) ? '0 : out_idx_q + CNT_W'(1);
        frame_done_d = out_hs & hs.out_last;
    end

    // state register, asynchronously cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q          <= '0;
            in_idx_q     <= '0;
            out_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            v_q          <= v_d;
            in_idx_q     <= in_idx_d;
            out_idx_q    <= out_idx_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_shift_register_group_ctrl.sv
// tb_shift_register_group_ctrl: directed and randomized checks against a slot-queue model of the delay group
module tb_shift_register_group_ctrl;
    localparam int FL = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        sr_enable, sr_clear, frame_done, busy;
    logic [1:0]  occupancy;
    logic [17:0] in_data;
    logic [17:0] grp [3];

    shift_register_group_ctrl_if hs();

    shift_register_group_ctrl #(.DEPTH(3), .FRAME_LEN(FL), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .flush(flush), .hs(hs),
        .sr_enable(sr_enable), .sr_clear(sr_clear), .frame_done(frame_done),
        .occupancy(occupancy), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // stand-in for the delay group: enable-gated shift with synchronous active-high clear
    always @(posedge clk) begin
        if (sr_clear) begin
            grp[0] <= '0;
            grp[1] <= '0;
            grp[2] <= '0;
        end else if (sr_enable) begin
            grp[0] <= in_data;
            grp[1] <= grp[0];
            grp[2] <= grp[1];
        end
    end

    // reference model: three slots holding a sequence number or -1 for a bubble
    int m_pipe [3] = '{-1, -1, -1};
    int m_oidx = 0;
    int m_seq = 0;
    bit m_fd = 1'b0;
    bit m_ohs;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pipe = '{-1, -1, -1};
            m_oidx = 0;
            m_fd = 1'b0;
            m_seq = 0;
        end else if (flush) begin
            m_pipe = '{-1, -1, -1};
            m_oidx = 0;
            m_fd = 1'b0;
        end else begin
            m_ohs = m_pipe[2] >= 0 && hs.out_ready;
            m_fd = m_ohs && m_oidx == FL - 1;
            if (m_ohs) m_oidx = (m_oidx + 1) % FL;
            if (m_pipe[2] < 0 || hs.out_ready) begin
                m_pipe[2] = m_pipe[1];
                m_pipe[1] = m_pipe[0];
                m_pipe[0] = hs.in_valid ? m_seq : -1;
                if (hs.in_valid) m_seq++;
            end
        end
    end

    int ncyc = 0;
    int first_acc = -1, first_ov = -1, first_oh = -1, last_oh = -1;
    int n_out = 0, last_pos = -1, fd_cnt = 0, fd_at = -1;
    bit e_ov, e_adv;
    int e_occ;

    // per-cycle comparison against the model, plus frame bookkeeping for the directed checks
    always @(negedge clk) begin
        ncyc++;
        e_ov  = m_pipe[2] >= 0;
        e_occ = int'(m_pipe[0] >= 0) + int'(m_pipe[1] >= 0) + int'(m_pipe[2] >= 0);
        e_adv = !flush && reset && !(e_ov && !hs.out_ready);
        chk("out_valid", int'(hs.out_valid), int'(e_ov));
        chk("out_last", int'(hs.out_last), int'(e_ov && m_oidx == FL - 1));
        chk("in_ready", int'(hs.in_ready), int'(e_adv));
        chk("sr_enable", int'(sr_enable), int'(e_adv));
        chk("sr_clear", int'(sr_clear), int'(!reset || flush));
        chk("occupancy", int'(occupancy), e_occ);
        chk("busy", int'(busy), int'(e_occ != 0));
        chk("frame_done", int'(frame_done), int'(m_fd));
        if (e_ov) chk("out_data", int'(grp[2]), m_pipe[2]);
        if (hs.in_valid && hs.in_ready && first_acc < 0) first_acc = ncyc;
        if (hs.out_valid && first_ov < 0) first_ov = ncyc;
        if (hs.out_valid && hs.out_ready && !flush) begin
            if (first_oh < 0) first_oh = ncyc;
            last_oh = ncyc;
            if (hs.out_last) last_pos = n_out;
            n_out++;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_at = n_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        in_data = 18'(m_seq);
    endtask

    task automatic run_frame(string tag);
        n_out = 0;
        last_pos = -1;
        fd_cnt = 0;
        hs.out_ready = 1'b1;
        hs.in_valid = 1'b1;
        repeat (FL) step();
        hs.in_valid = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk({tag, "_n_out"}, n_out, 32);
        chk({tag, "_last_pos"}, last_pos, 31);
        chk({tag, "_frame_done_cnt"}, fd_cnt, 1);
        chk({tag, "_occ_end"}, int'(occupancy), 0);
    endtask

    int base;

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        hs.in_valid = 1'b0;
        hs.out_ready = 1'b0;
        in_data = '0;
        @(negedge clk);
        chk("rst_in_ready", int'(hs.in_ready), 0);
        chk("rst_sr_enable", int'(sr_enable), 0);
        chk("rst_sr_clear", int'(sr_clear), 1);
        chk("rst_occ", int'(occupancy), 0);
        chk("rst_out_valid", int'(hs.out_valid), 0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("release_in_ready", int'(hs.in_ready), 1);

        // full-rate frame with latency and throughput pins
        hs.out_ready = 1'b1;
        hs.in_valid = 1'b1;
        repeat (FL) step();
        hs.in_valid = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("latency", first_ov - first_acc, 3);
        chk("throughput_span", last_oh - first_oh, 31);
        chk("frame_n_out", n_out, 32);
        chk("frame_last_pos", last_pos, 31);
        chk("frame_done_cnt", fd_cnt, 1);
        chk("frame_done_after_last", fd_at, 32);
        chk("frame_occ_end", int'(occupancy), 0);

        // backpressure stall with three live stages
        step();
        hs.out_ready = 1'b0;
        base = m_seq;
        hs.in_valid = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_sr_enable", int'(sr_enable), 0);
            chk("stall_in_ready", int'(hs.in_ready), 0);
            chk("stall_occ", int'(occupancy), 3);
            chk("stall_hold_data", int'(grp[2]), base);
            step();
        end
        hs.in_valid = 1'b0;
        hs.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("release_valid", int'(hs.out_valid), 1);
            chk("release_data", int'(grp[2]), base + i);
            step();
        end
        repeat (3) step();

        // alternate-cycle input
        for (int i = 0; i < 16; i++) begin
            hs.in_valid = (i % 2 == 0);
            @(negedge clk);
            if (i >= 3) chk("alt_occ", int'(occupancy), hs.out_valid ? 2 : 1);
            step();
        end
        hs.in_valid = 1'b0;
        repeat (4) step();

        // flush with two live vectors
        hs.in_valid = 1'b1;
        repeat (2) step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_sr_clear", int'(sr_clear), 1);
        chk("flush_in_ready", int'(hs.in_ready), 0);
        step();
        flush = 1'b0;
        hs.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("flush_occ", int'(occupancy), 0);
            chk("flush_no_out", int'(hs.out_valid), 0);
            step();
        end
        run_frame("post_flush");

        // reset mid-stream with three live vectors
        hs.out_ready = 1'b0;
        hs.in_valid = 1'b1;
        repeat (3) step();
        hs.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", int'(hs.out_valid), 0);
        chk("midrst_occ", int'(occupancy), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(hs.in_ready), 0);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            chk("midrst_sr_clear", int'(sr_clear), 1);
        end
        step();
        reset = 1'b1;
        run_frame("post_reset");

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 4000; i++) begin
            step();
            hs.in_valid = $urandom_range(0, 3) != 0;
            hs.out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 49) == 0;
            reset = $urandom_range(0, 299) != 0;
        end
        step();
        reset = 1'b1;
        flush = 1'b0;
        hs.in_valid = 1'b0;
        hs.out_ready = 1'b1;
        repeat (5) step();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
